// File: rtl/sram_resp_pkg.sv
// Shared types for the sram_resp responder: FSM state encoding and word geometry.
package sram_resp_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int WORD_BYTES = 4;
endpackage

// File: rtl/sram_resp_mem.sv
// Single-port word RAM with synchronous read and per-byte write enables.
// A write cycle leaves rdata untouched so a pending read response stays stable.
module sram_resp_mem
  import sram_resp_pkg::*;
#(
  parameter int ADDR_W = 14
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [WORD_BYTES-1:0] be,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);
  logic [31:0] ram [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < WORD_BYTES; i++) begin
          if (be[i]) ram[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= ram[addr];
      end
    end
  end
endmodule

// File: rtl/sram_resp.sv
// Memory-request responder: accepts one word request, waits WAIT_CYCLES, answers via valid/ready.
// Optional byte strobes (req_wstrb) are enabled by defining SRAM_RESP_BYTE_EN.
//
// state | meaning
// IDLE  | ready for a request; req_ready high
// WAIT  | request latched, counting wait states
// RESP  | response held on resp_* until resp_ready
module sram_resp
  import sram_resp_pkg::*;
#(
  parameter int          ADDR_W      = 14,
  parameter logic [31:0] BASE_ADDR   = 32'h1c000000,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
`ifdef SRAM_RESP_BYTE_EN
  input  logic [3:0]  req_wstrb,
`endif
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);
  localparam logic [3:0] CNT_LAST = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t      state, state_next;
  logic [3:0]  cnt;
  logic        we_q;
  logic [31:0] addr_q, wdata_q;
  logic        err_q, rd_ok_q;
  logic        enter_resp;
  logic        cur_we, cur_err;
  logic [31:0] cur_addr, cur_wdata, off;
  logic [3:0]  cur_strb;
  logic [31:0] mem_rdata;

  // With zero wait states RAM is accessed on the accept edge, so use the live request.
  assign cur_we    = (state == IDLE) ? req_we    : we_q;
  assign cur_addr  = (state == IDLE) ? req_addr  : addr_q;
  assign cur_wdata = (state == IDLE) ? req_wdata : wdata_q;
`ifdef SRAM_RESP_BYTE_EN
  logic [3:0] wstrb_q;
  assign cur_strb = (state == IDLE) ? req_wstrb : wstrb_q;
`else
  assign cur_strb = 4'hf;
`endif

  // Base is word aligned, so off[1:0] equals the address alignment bits.
  assign off     = cur_addr - BASE_ADDR;
  assign cur_err = (|off[1:0]) | (|off[31:ADDR_W+2]);

  always_comb begin
    state_next = state;
    enter_resp = 1'b0;
    case (state)
      IDLE: if (req_valid) begin
        if (WAIT_CYCLES == 0) begin
          state_next = RESP;
          enter_resp = 1'b1;
        end else begin
          state_next = WAIT;
        end
      end
      WAIT: if (cnt == CNT_LAST) begin
        state_next = RESP;
        enter_resp = 1'b1;
      end
      RESP: if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      err_q   <= 1'b0;
      rd_ok_q <= 1'b0;
`ifdef SRAM_RESP_BYTE_EN
      wstrb_q <= 4'd0;
`endif
    end else begin
      state <= state_next;
      if (state == IDLE && req_valid) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        cnt     <= 4'd0;
`ifdef SRAM_RESP_BYTE_EN
        wstrb_q <= req_wstrb;
`endif
      end else if (state == WAIT) begin
        cnt <= cnt + 4'd1;
      end
      if (enter_resp) begin
        err_q   <= cur_err;
        rd_ok_q <= !cur_we && !cur_err;
      end else if (state == RESP && resp_ready) begin
        err_q   <= 1'b0;
        rd_ok_q <= 1'b0;
      end
    end
  end

  sram_resp_mem #(.ADDR_W(ADDR_W)) u_mem (
    .clk   (clk),
    .en    (enter_resp && !reset),
    .we    (cur_we && !cur_err),
    .addr  (off[ADDR_W+1:2]),
    .be    (cur_strb),
    .wdata (cur_wdata),
    .rdata (mem_rdata)
  );

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign resp_err   = err_q;
  assign resp_rdata = rd_ok_q ? mem_rdata : 32'd0;
endmodule

// File: tb/tb_sram_resp.sv
// Directed bench for sram_resp: vector table on a WAIT_CYCLES=1 instance plus
// hand-written sequences for stalls, reset abort and a zero-wait back-to-back instance.
module tb_sram_resp;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        req_valid, req_ready, req_we, resp_valid, resp_ready, resp_err;
  logic [31:0] req_addr, req_wdata, resp_rdata;
  logic [3:0]  req_wstrb;

  logic        r0_valid, r0_ready, r0_we, r0_resp_valid, r0_resp_ready, r0_err;
  logic [31:0] r0_addr, r0_wdata, r0_rdata;

  int checks = 0;
  int errors = 0;

  sram_resp #(.ADDR_W(14), .BASE_ADDR(32'h1c000000), .WAIT_CYCLES(1)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
`ifdef SRAM_RESP_BYTE_EN
    .req_wstrb  (req_wstrb),
`endif
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  sram_resp #(.ADDR_W(14), .BASE_ADDR(32'h1c000000), .WAIT_CYCLES(0)) u_dut0 (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (r0_valid),
    .req_ready  (r0_ready),
    .req_we     (r0_we),
    .req_addr   (r0_addr),
    .req_wdata  (r0_wdata),
`ifdef SRAM_RESP_BYTE_EN
    .req_wstrb  (4'hf),
`endif
    .resp_valid (r0_resp_valid),
    .resp_ready (r0_resp_ready),
    .resp_rdata (r0_rdata),
    .resp_err   (r0_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction on u_dut; lat counts cycles from the presenting cycle to resp_valid.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, output logic [31:0] rdata,
                        output logic err, output int lat);
    int t;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = strb;
    resp_ready = 1'b1;
    t = 0;
    while (!req_ready && t < 50) begin tick(); t++; end
    tick();
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 50) begin tick(); lat++; end
    rdata = resp_rdata;
    err = resp_err;
    tick();
  endtask

  // Streams words 0..3 through u_dut0 with req_valid held high; checks data and spacing.
  task automatic burst0(input logic we);
    int k, rcount, last;
    logic accepting;
    k = 0; rcount = 0; last = 0;
    r0_resp_ready = 1'b1;
    r0_we = we;
    for (int cyc = 0; cyc < 30 && rcount < 4; cyc++) begin
      r0_valid = (k < 4);
      r0_addr  = 32'h1c000000 + 32'(4 * k);
      r0_wdata = 32'h100 + 32'(k);
      accepting = r0_ready && r0_valid;
      tick();
      if (accepting) k++;
      if (r0_resp_valid) begin
        chk(we ? "b2b_wr_rdata" : "b2b_rd_rdata", r0_rdata, we ? 32'd0 : 32'h100 + 32'(rcount));
        if (rcount > 0) chk("b2b_interval", 32'(cyc - last), 32'd2);
        last = cyc;
        rcount++;
      end
    end
    r0_valid = 1'b0;
    chk("b2b_count", 32'(rcount), 32'd4);
  endtask

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[11];
  logic [31:0] rd;
  logic        er;
  int          lat;

  initial begin
    vecs[0]  = '{"wr_10",        1'b1, 32'h1c000010, 32'hdeadbeef, 32'h0,        1'b0};
    vecs[1]  = '{"rd_10",        1'b0, 32'h1c000010, 32'h0,        32'hdeadbeef, 1'b0};
    vecs[2]  = '{"wr_00",        1'b1, 32'h1c000000, 32'hcafef00d, 32'h0,        1'b0};
    vecs[3]  = '{"rd_misalign",  1'b0, 32'h1c000002, 32'h0,        32'h0,        1'b1};
    vecs[4]  = '{"rd_below",     1'b0, 32'h1bfffffc, 32'h0,        32'h0,        1'b1};
    vecs[5]  = '{"wr_above",     1'b1, 32'h1c010000, 32'h12345678, 32'h0,        1'b1};
    vecs[6]  = '{"rd_00_intact", 1'b0, 32'h1c000000, 32'h0,        32'hcafef00d, 1'b0};
    vecs[7]  = '{"wr_last",      1'b1, 32'h1c00fffc, 32'h0badf00d, 32'h0,        1'b0};
    vecs[8]  = '{"rd_last",      1'b0, 32'h1c00fffc, 32'h0,        32'h0badf00d, 1'b0};
    vecs[9]  = '{"wr_misalign",  1'b1, 32'h1c000002, 32'h55555555, 32'h0,        1'b1};
    vecs[10] = '{"rd_00_again",  1'b0, 32'h1c000000, 32'h0,        32'hcafef00d, 1'b0};

    reset = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = 4'hf;
    resp_ready = 1'b1;
    r0_valid = 1'b0; r0_we = 1'b0; r0_addr = '0; r0_wdata = '0; r0_resp_ready = 1'b1;
    tick(); tick();
    reset = 1'b0;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);

    for (int i = 0; i < 11; i++) begin
      do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, 4'hf, rd, er, lat);
      chk({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rdata);
      chk({vecs[i].name, "_err"}, 32'(er), 32'(vecs[i].exp_err));
      chk({vecs[i].name, "_latency"}, 32'(lat), 32'd2);
    end

    // Stalled response, with a new request raised while the response is still pending.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h1c000010; resp_ready = 1'b0;
    tick();
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 50) begin tick(); lat++; end
    chk("stall_latency", 32'(lat), 32'd2);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("stall_resp_valid", 32'(resp_valid), 32'd1);
      chk("stall_rdata", resp_rdata, 32'hdeadbeef);
      chk("stall_req_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b1; req_addr = 32'h1c000000; resp_ready = 1'b1;
    tick();
    chk("release_req_ready", 32'(req_ready), 32'd1);
    chk("release_resp_valid", 32'(resp_valid), 32'd0);
    tick();
    chk("late_accept_req_ready", 32'(req_ready), 32'd0);
    req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 50) begin tick(); lat++; end
    chk("late_accept_rdata", resp_rdata, 32'hcafef00d);
    tick();

    // Reset during WAIT of a write abandons it.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h1c000010; req_wdata = 32'hffffffff;
    tick();
    req_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_req_ready", 32'(req_ready), 32'd1);
    chk("abort_resp_valid", 32'(resp_valid), 32'd0);
    do_req(1'b0, 32'h1c000010, 32'h0, 4'hf, rd, er, lat);
    chk("abort_word_kept", rd, 32'hdeadbeef);

`ifdef SRAM_RESP_BYTE_EN
    do_req(1'b1, 32'h1c000020, 32'h11223344, 4'hf, rd, er, lat);
    do_req(1'b1, 32'h1c000020, 32'haabbccdd, 4'b0101, rd, er, lat);
    do_req(1'b0, 32'h1c000020, 32'h0, 4'hf, rd, er, lat);
    chk("strobe_merge", rd, 32'h11bb33dd);
    do_req(1'b1, 32'h1c000020, 32'h99999999, 4'b0000, rd, er, lat);
    chk("strobe_none_err", 32'(er), 32'd0);
    chk("strobe_none_latency", 32'(lat), 32'd2);
    do_req(1'b0, 32'h1c000020, 32'h0, 4'hf, rd, er, lat);
    chk("strobe_none_kept", rd, 32'h11bb33dd);
`endif

    burst0(1'b1);
    burst0(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
